// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and constants for the uart framing transmitter.
package uart_frame_pkg;

   localparam int         LEN_W       = 8;
   localparam logic [7:0] SOF_DEFAULT = 8'h7E;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STROBE,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_SOF,
      PH_LEN,
      PH_PAY,
      PH_CSUM
   } phase_t;

endpackage

// File: rtl/uart_frame_fifo.sv
// uart_frame_fifo: synchronous payload FIFO with registered count/full and
// an overflow pulse when a push arrives while full (the byte is dropped).
module uart_frame_fifo
   import uart_frame_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      cnt_nxt = count;
      case ({do_push, do_pop})
         2'b10:   cnt_nxt = count + CNT_W'(1);
         2'b01:   cnt_nxt = count - CNT_W'(1);
         default: cnt_nxt = count;
      endcase
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count    <= cnt_nxt;
         full     <= (cnt_nxt == CNT_W'(DEPTH));
         overflow <= push && full;
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: frames queued payload bytes as SOF, LEN, payload[, CSUM] and
// hands them one at a time to a uart byte transmitter.
// Build option: define UART_FRAME_CSUM_EN to append an XOR checksum byte
// (LEN ^ all payload bytes) after the payload.
module uart_frame_tx
   import uart_frame_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [7:0]                   wr_data,
   output logic                         fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow,
   input  logic                         frame_go,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         uart_transmit,
   output logic [7:0]                   uart_tx_byte,
   input  logic                         uart_is_transmitting
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_nxt;
   phase_t            phase;
   phase_t            phase_nxt;
   logic [CNT_W-1:0]  rem;
   logic [CNT_W-1:0]  rem_nxt;
   logic [LEN_W-1:0]  len;
   logic              start;
   logic              pop;
   logic              fifo_empty;
   logic [7:0]        fifo_rd_data;
   logic [7:0]        byte_sel;
`ifdef UART_FRAME_CSUM_EN
   logic [7:0]        csum;
`endif

   uart_frame_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (wr_en),
      .pop      (pop),
      .wr_data  (wr_data),
      .rd_data  (fifo_rd_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .overflow (overflow)
   );

   // Next-state logic: walk SOF, LEN, each payload byte and the optional checksum.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      rem_nxt   = rem;
      start     = 1'b0;
      pop       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (frame_go && !fifo_empty) begin
               start     = 1'b1;
               phase_nxt = PH_SOF;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            pop       = (phase == PH_PAY);
            state_nxt = ST_STROBE;
         end
         ST_STROBE: begin
            state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (uart_is_transmitting) state_nxt = ST_WAIT_IDLE;
         end
         ST_WAIT_IDLE: begin
            if (!uart_is_transmitting) begin
               state_nxt = ST_LOAD;
               unique case (phase)
                  PH_SOF: phase_nxt = PH_LEN;
                  PH_LEN: phase_nxt = PH_PAY;
                  PH_PAY: begin
                     if (rem == CNT_W'(1)) begin
`ifdef UART_FRAME_CSUM_EN
                        phase_nxt = PH_CSUM;
`else
                        state_nxt = ST_DONE;
`endif
                     end else begin
                        rem_nxt = rem - CNT_W'(1);
                     end
                  end
                  PH_CSUM: state_nxt = ST_DONE;
                  default: state_nxt = ST_DONE;
               endcase
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte presented to the uart for the current phase.
   always_comb begin
      byte_sel = SOF_BYTE;
      unique case (phase)
         PH_SOF:  byte_sel = SOF_BYTE;
         PH_LEN:  byte_sel = len;
         PH_PAY:  byte_sel = fifo_rd_data;
`ifdef UART_FRAME_CSUM_EN
         PH_CSUM: byte_sel = csum;
`else
         PH_CSUM: byte_sel = SOF_BYTE;
`endif
         default: byte_sel = SOF_BYTE;
      endcase
   end

   // FSM state, phase and remaining-payload counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         phase <= PH_SOF;
         rem   <= '0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
         rem   <= start ? fifo_count : rem_nxt;
      end
   end

   // Frame length captured at go; later pushes belong to the next frame.
   always_ff @(posedge clk) begin
      if (start) len <= LEN_W'(fifo_count);
   end

`ifdef UART_FRAME_CSUM_EN
   // Running checksum seeded with LEN, folded with each byte as it leaves the FIFO.
   always_ff @(posedge clk) begin
      if (start)    csum <= LEN_W'(fifo_count);
      else if (pop) csum <= csum ^ fifo_rd_data;
   end
`endif

   // Registered outputs derived from the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= '0;
      end else begin
         busy          <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
         frame_done    <= (state_nxt == ST_DONE);
         uart_transmit <= (state_nxt == ST_STROBE);
         if (state == ST_LOAD) uart_tx_byte <= byte_sel;
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: scoreboard bench for uart_frame_tx with a behavioural
// uart byte transmitter standing in for the real uart.
module tb_uart_frame_tx;

   localparam int         DEPTH    = 16;
   localparam logic [7:0] SOF      = 8'h7E;
   localparam int         UART_CYC = 6;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       fifo_full;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       frame_go;
   logic       busy;
   logic       frame_done;
   logic       uart_transmit;
   logic [7:0] uart_tx_byte;
   logic       uart_is_transmitting;

   int         n_checks = 0;
   int         n_errors = 0;
   int         tx_total = 0;
   int         done_cnt = 0;
   int         utx_cnt  = 0;
   logic       prev_tx  = 1'b0;
   logic       prev_done = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] mdl_q [$];

   uart_frame_tx #(
      .FIFO_DEPTH (DEPTH),
      .SOF_BYTE   (SOF)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .wr_en                (wr_en),
      .wr_data              (wr_data),
      .fifo_full            (fifo_full),
      .fifo_count           (fifo_count),
      .overflow             (overflow),
      .frame_go             (frame_go),
      .busy                 (busy),
      .frame_done           (frame_done),
      .uart_transmit        (uart_transmit),
      .uart_tx_byte         (uart_tx_byte),
      .uart_is_transmitting (uart_is_transmitting)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign uart_is_transmitting = (utx_cnt != 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // uart model and byte monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (uart_transmit) begin
         tx_total++;
         check("strobe_1cyc", 32'(prev_tx), 32'd0);
         if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'(uart_tx_byte), 32'hFFFF_FFFF);
         end else begin
            check("rx_byte", 32'(uart_tx_byte), 32'(exp_q.pop_front()));
         end
         utx_cnt = UART_CYC;
      end else if (utx_cnt != 0) begin
         utx_cnt--;
      end
      if (frame_done) begin
         done_cnt++;
         check("done_1cyc", 32'(prev_done), 32'd0);
         check("done_busy", 32'(busy), 32'd0);
      end
      prev_tx   = uart_transmit;
      prev_done = frame_done;
   end

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      if (mdl_q.size() < DEPTH) mdl_q.push_back(b);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic build_frame();
      logic [7:0] len;
      logic [7:0] cs;
      logic [7:0] b;
      len = 8'(mdl_q.size());
      cs  = len;
      exp_q.push_back(SOF);
      exp_q.push_back(len);
      while (mdl_q.size() != 0) begin
         b = mdl_q.pop_front();
         cs = cs ^ b;
         exp_q.push_back(b);
      end
`ifdef UART_FRAME_CSUM_EN
      exp_q.push_back(cs);
`endif
   endtask

   task automatic go_frame(input bit accept);
      if (accept) build_frame();
      frame_go = 1'b1;
      @(posedge clk);
      #1;
      frame_go = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0);
      for (int i = 0; i < 4000; i++) begin
         if (done_cnt > d0) break;
         @(posedge clk);
         #1;
      end
      check({tag, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
      check({tag, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int t0;
      rst      = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      frame_go = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",     32'(busy),          32'd0);
      check("rst_done",     32'(frame_done),    32'd0);
      check("rst_transmit", 32'(uart_transmit), 32'd0);
      check("rst_tx_byte",  32'(uart_tx_byte),  32'd0);
      check("rst_count",    32'(fifo_count),    32'd0);
      check("rst_full",     32'(fifo_full),     32'd0);
      check("rst_overflow", 32'(overflow),      32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // basic three-byte frame, including first-strobe latency
      push(8'h01); push(8'h02); push(8'h03);
      check("basic_count", 32'(fifo_count), 32'd3);
      d0 = done_cnt;
      go_frame(1);
      check("basic_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("first_strobe", 32'(uart_transmit), 32'd1);
      check("first_byte",   32'(uart_tx_byte),  32'(SOF));
      wait_done("basic", d0);
      check("basic_count_after", 32'(fifo_count), 32'd0);
      check("basic_busy_after",  32'(busy),       32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("basic_one_done", 32'(done_cnt), 32'(d0 + 1));

      // go with an empty FIFO is ignored
      t0 = tx_total;
      d0 = done_cnt;
      go_frame(0);
      repeat (30) @(posedge clk);
      #1;
      check("empty_no_tx",   32'(tx_total), 32'(t0));
      check("empty_no_done", 32'(done_cnt), 32'(d0));
      check("empty_busy",    32'(busy),     32'd0);

      // fill to depth, then overflow
      for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
      check("fill_full",  32'(fifo_full),  32'd1);
      check("fill_count", 32'(fifo_count), 32'(DEPTH));
      push(8'hEE);
      check("ovf_pulse", 32'(overflow),   32'd1);
      check("ovf_count", 32'(fifo_count), 32'(DEPTH));
      @(posedge clk);
      #1;
      check("ovf_clear", 32'(overflow), 32'd0);
      d0 = done_cnt;
      go_frame(1);
      wait_done("full", d0);

      // bytes written during a frame wait for the next one
      push(8'h11); push(8'h22);
      d0 = done_cnt;
      go_frame(1);
      push(8'h33); push(8'h44); push(8'h55);
      wait_done("split1", d0);
      check("split_count", 32'(fifo_count), 32'd3);
      d0 = done_cnt;
      go_frame(1);
      wait_done("split2", d0);

      // reset during the first payload strobe
      for (int i = 0; i < 5; i++) push(8'(8'hA1 + i));
      go_frame(1);
      t0 = tx_total;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (uart_transmit && tx_total == t0 + 2) break;
      end
      check("mid_strobe_found", 32'(uart_transmit), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_transmit", 32'(uart_transmit), 32'd0);
      check("mid_rst_busy",     32'(busy),          32'd0);
      check("mid_rst_count",    32'(fifo_count),    32'd0);
      exp_q.delete();
      mdl_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (!uart_is_transmitting) break;
         @(posedge clk);
         #1;
      end
      check("uart_idle_after_rst", 32'(uart_is_transmitting), 32'd0);
      push(8'hAA); push(8'hBB);
      d0 = done_cnt;
      go_frame(1);
      wait_done("post_rst", d0);

      // go held high for the whole frame starts exactly one frame
      push(8'hC5);
      d0 = done_cnt;
      build_frame();
      frame_go = 1'b1;
      wait_done("held", d0);
      repeat (30) @(posedge clk);
      #1;
      frame_go = 1'b0;
      check("held_one_frame", 32'(done_cnt), 32'(d0 + 1));

      // back-to-back frames
      push(8'h5A); push(8'hA5);
      d0 = done_cnt;
      go_frame(1);
      wait_done("b2b1", d0);
      push(8'h0F);
      d0 = done_cnt;
      go_frame(1);
      wait_done("b2b2", d0);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
